// File: rtl/gfx256_pixel_coalescer.sv
// Write-combining stage: merges single-pixel writes that hit the same 32-byte line and
// issues one masked 256-bit bus write per line. Optional idle flush: GFX_COALESCE_TIMEOUT_EN.
//
// state | meaning
// EMPTY | no buffered bytes, accepts any pixel
// FILL  | line buffer open, accepts pixels with matching tag
// WRITE | bus write of the buffered line until ack
module gfx256_pixel_coalescer #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    input  logic [AW-1:0] pix_adr_i,
    input  logic [31:0]   pix_color_i,
    input  logic [1:0]    pix_depth_i,
    input  logic          flush_i,
    output logic          idle_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_adr_o,
    output logic [255:0]  m_dat_o,
    output logic [31:0]   m_sel_o,
    input  logic          m_ack_i
);

    localparam int TW = AW - 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tag_q;
    logic [255:0]    buf_q;
    logic [31:0]     sel_q;
    logic            cyc_q;
    logic [AW-1:0]   adr_q;
    logic [255:0]    dat_q;
    logic [31:0]     msel_q;
    logic            idle_q;

    logic [TW-1:0]   pix_tag;
    logic [4:0]      pix_off;
    logic            tag_hit;
    logic            sel_full;
    logic            timeout_hit;
    logic            accept;
    logic [255:0]    merge_dat;
    logic [31:0]     merge_sel;

    assign pix_tag  = pix_adr_i[AW-1:5];
    assign pix_off  = pix_adr_i[4:0];
    assign tag_hit  = (pix_tag == tag_q);
    assign sel_full = &sel_q;
    assign accept   = pix_valid_i & pix_ready_o;

    // Bytes past the end of the line fall out naturally: rel is computed 6-bit wide,
    // so positions below the offset wrap to large values instead of into this line.
    always_comb begin
        logic [5:0] rel;
        logic [7:0] byte_v;
        rel       = '0;
        byte_v    = '0;
        merge_dat = buf_q;
        merge_sel = sel_q;
        for (int j = 0; j < 32; j++) begin
            rel = 6'(j) - {1'b0, pix_off};
            if (rel <= {4'b0, pix_depth_i}) begin
                case (rel[1:0])
                    2'd0:    byte_v = pix_color_i[7:0];
                    2'd1:    byte_v = pix_color_i[15:8];
                    2'd2:    byte_v = pix_color_i[23:16];
                    default: byte_v = pix_color_i[31:24];
                endcase
                merge_dat[j*8 +: 8] = byte_v;
                merge_sel[j]        = 1'b1;
            end
        end
    end

`ifdef GFX_COALESCE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt_q;

    assign timeout_hit = (state_q == FILL) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q != FILL || accept || timeout_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    // TIMEOUT is never 0, so this is a constant low; no idle flush in this build.
    assign timeout_hit = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d     = state_q;
        pix_ready_o = 1'b0;
        case (state_q)
            EMPTY: begin
                pix_ready_o = rst_ni;
                if (pix_valid_i && rst_ni) state_d = FILL;
            end
            FILL: begin
                if (flush_i || sel_full || timeout_hit || (pix_valid_i && !tag_hit)) begin
                    state_d = WRITE;
                end else begin
                    pix_ready_o = pix_valid_i;
                end
            end
            WRITE: begin
                if (cyc_q && m_ack_i) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d == EMPTY);
        end
    end

    // Bus signals are loaded one cycle after entering WRITE so they come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q  <= '0;
            buf_q  <= '0;
            sel_q  <= '0;
            cyc_q  <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            msel_q <= '0;
        end else begin
            if (accept) begin
                tag_q <= pix_tag;
                buf_q <= merge_dat;
                sel_q <= merge_sel;
            end
            if (state_q == WRITE) begin
                if (!cyc_q) begin
                    cyc_q  <= 1'b1;
                    adr_q  <= {tag_q, 5'b0};
                    dat_q  <= buf_q;
                    msel_q <= sel_q;
                end else if (m_ack_i) begin
                    cyc_q  <= 1'b0;
                    adr_q  <= '0;
                    dat_q  <= '0;
                    msel_q <= '0;
                    buf_q  <= '0;
                    sel_q  <= '0;
                end
            end
        end
    end

    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o  = cyc_q;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
    assign m_sel_o = msel_q;
    assign idle_o  = idle_q;

endmodule

// File: tb/tb_gfx256_pixel_coalescer.sv
// Bench for gfx256_pixel_coalescer: directed line scenarios plus random pixel streams
// checked against a byte-array model of the line write combiner.
module tb_gfx256_pixel_coalescer;

    localparam int TMO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          pix_valid_i = 1'b0;
    logic          pix_ready_o;
    logic [31:0]   pix_adr_i = '0;
    logic [31:0]   pix_color_i = '0;
    logic [1:0]    pix_depth_i = '0;
    logic          flush_i = 1'b0;
    logic          idle_o;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [31:0]   m_adr_o;
    logic [255:0]  m_dat_o;
    logic [31:0]   m_sel_o;
    logic          m_ack_i = 1'b0;

    gfx256_pixel_coalescer #(.AW(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .pix_adr_i(pix_adr_i), .pix_color_i(pix_color_i), .pix_depth_i(pix_depth_i),
        .flush_i(flush_i), .idle_o(idle_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [31:0]  adr;
        logic [255:0] dat;
        logic [31:0]  sel;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  auto_ack = 1'b1;
    int  ack_delay = 0;
    int  rise_cyc = 0;
    int  ack_cyc = 0;
    int  acc_cyc = 0;

    // Reference line buffer
    logic [7:0]  mb[32];
    bit          ms[32];
    logic [26:0] mline;
    bit          mvalid = 1'b0;

    // Bus responder: records each write, acks after ack_delay cycles
    initial begin
        wr_t w;
        forever begin
            @(posedge clk_i); #1;
            if (auto_ack && m_cyc_o) begin
                w.adr = m_adr_o; w.dat = m_dat_o; w.sel = m_sel_o;
                obs_q.push_back(w);
                rise_cyc = cyc_cnt;
                repeat (ack_delay) begin @(posedge clk_i); #1; end
                m_ack_i = 1'b1;
                @(posedge clk_i); #1;
                ack_cyc = cyc_cnt;
                m_ack_i = 1'b0;
            end
        end
    end

    task automatic model_emit();
        wr_t w;
        w.adr = {mline, 5'b0};
        w.dat = '0;
        w.sel = '0;
        for (int b = 0; b < 32; b++) begin
            if (ms[b]) begin
                w.dat[b*8 +: 8] = mb[b];
                w.sel[b] = 1'b1;
            end
            ms[b] = 1'b0;
            mb[b] = 8'h00;
        end
        exp_q.push_back(w);
        mvalid = 1'b0;
    endtask

    task automatic model_pix(input logic [31:0] adr, input logic [31:0] col, input int dep);
        int off;
        int nset;
        off = int'(adr[4:0]);
        if (mvalid && adr[31:5] != mline) model_emit();
        if (!mvalid) begin
            mvalid = 1'b1;
            mline = adr[31:5];
            for (int b = 0; b < 32; b++) begin ms[b] = 1'b0; mb[b] = 8'h00; end
        end
        for (int k = 0; k <= dep; k++) begin
            if (off + k < 32) begin
                mb[off+k] = col[8*k +: 8];
                ms[off+k] = 1'b1;
            end
        end
        nset = 0;
        for (int b = 0; b < 32; b++) nset += int'(ms[b]);
        if (nset == 32) model_emit();
    endtask

    task automatic model_flush();
        if (mvalid) model_emit();
    endtask

    task automatic send_pix(input logic [31:0] adr, input logic [31:0] col, input logic [1:0] dep);
        bit done;
        done = 1'b0;
        pix_valid_i = 1'b1;
        pix_adr_i = adr;
        pix_color_i = col;
        pix_depth_i = dep;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            if (pix_ready_o) begin
                @(posedge clk_i); #1;
                acc_cyc = cyc_cnt;
                done = 1'b1;
            end
        end
        pix_valid_i = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: pixel at %h never accepted", adr);
        end
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (idle_o && !m_cyc_o && !m_ack_i) done = 1'b1;
            else begin @(posedge clk_i); #1; end
        end
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout: idle=%b cyc=%b", idle_o, m_cyc_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({pix_ready_o, m_cyc_o, m_stb_o, m_we_o, idle_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/cyc/stb/we/idle=%b expected 00001",
                     {pix_ready_o, m_cyc_o, m_stb_o, m_we_o, idle_o});
        end
        checks++;
        if (m_adr_o !== 32'h0 || m_dat_o !== 256'h0 || m_sel_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: adr=%h sel=%h dat=%h expected all zero", m_adr_o, m_sel_o, m_dat_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (pix_ready_o !== 1'b1 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b idle=%b expected 1 1", pix_ready_o, idle_o);
        end
    endtask

    task automatic test_span_8bpp();
        logic [255:0] exp_dat;
        obs_q.delete();
        ack_delay = 0;
        for (int i = 0; i < 32; i++) begin
            send_pix(32'h1000 + 32'(i), 32'(i), 2'd0);
            exp_dat[i*8 +: 8] = 8'(i);
        end
        send_pix(32'h1020, 32'h5A, 2'd0);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL span_count: got %0d writes before 0x1020 accept, expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].adr !== 32'h1000 || obs_q[0].sel !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL span_adr_sel: got adr=%h sel=%h expected 00001000 ffffffff",
                         obs_q[0].adr, obs_q[0].sel);
            end
            checks++;
            if (obs_q[0].dat !== exp_dat) begin
                errors++;
                $display("FAIL span_dat: got %h expected %h", obs_q[0].dat, exp_dat);
            end
        end
        checks++;
        if (acc_cyc !== ack_cyc + 1) begin
            errors++;
            $display("FAIL span_next_accept: accepted cycle %0d, expected %0d", acc_cyc, ack_cyc + 1);
        end
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== 2 || obs_q[obs_q.size()-1].adr !== 32'h1020 ||
            obs_q[obs_q.size()-1].sel !== 32'h1) begin
            errors++;
            $display("FAIL span_tail: got %0d writes, expected 2 with last at 00001020 sel 1", obs_q.size());
        end
    endtask

    task automatic test_mixed_depth();
        obs_q.delete();
        send_pix(32'h2004, 32'hAABB_CCDD, 2'd3);
        send_pix(32'h2006, 32'h0000_1122, 2'd1);
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL mixed_count: got %0d writes expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].sel !== 32'h0000_00F0 || obs_q[0].adr !== 32'h2000) begin
                errors++;
                $display("FAIL mixed_sel: got sel=%h adr=%h expected 000000f0 00002000",
                         obs_q[0].sel, obs_q[0].adr);
            end
            checks++;
            if (obs_q[0].dat !== {192'h0, 32'h1122_CCDD, 32'h0}) begin
                errors++;
                $display("FAIL mixed_dat: got %h expected dat[63:32]=1122ccdd rest 0", obs_q[0].dat);
            end
            checks++;
            if (rise_cyc !== acc_cyc + 2) begin
                errors++;
                $display("FAIL flush_latency: cyc rose at %0d expected %0d", rise_cyc, acc_cyc + 2);
            end
        end
    endtask

    task automatic test_line_end();
        obs_q.delete();
        send_pix(32'h301E, 32'h0012_3456, 2'd2);
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL lineend_count: got %0d writes expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].sel !== 32'hC000_0000 || obs_q[0].adr !== 32'h3000 ||
                obs_q[0].dat !== {16'h3456, 240'h0}) begin
                errors++;
                $display("FAIL lineend_write: got adr=%h sel=%h dat=%h expected 00003000 c0000000 3456 at top",
                         obs_q[0].adr, obs_q[0].sel, obs_q[0].dat);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0]  c1, c2;
        logic [31:0]  cap_adr, cap_sel;
        logic [255:0] cap_dat;
        bit           seen;
        c1 = $urandom;
        c2 = $urandom;
        obs_q.delete();
        auto_ack = 1'b0;
        send_pix(32'h4000, c1, 2'd3);
        fork
            send_pix(32'h5000, c2, 2'd3);
        join_none
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = m_cyc_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_no_cycle: no bus cycle after tag mismatch");
        end
        cap_adr = m_adr_o; cap_sel = m_sel_o; cap_dat = m_dat_o;
        checks++;
        if (cap_adr !== 32'h4000 || cap_sel !== 32'hF || cap_dat !== {224'h0, c1}) begin
            errors++;
            $display("FAIL bp_first_write: got adr=%h sel=%h dat=%h expected 00004000 f %h",
                     cap_adr, cap_sel, cap_dat, c1);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            checks++;
            if (pix_ready_o !== 1'b0 || {m_cyc_o, m_stb_o, m_we_o} !== 3'b111 ||
                m_adr_o !== cap_adr || m_sel_o !== cap_sel || m_dat_o !== cap_dat) begin
                errors++;
                $display("FAIL bp_hold_%0d: ready=%b cyc/stb/we=%b adr=%h sel=%h expected 0 111 %h %h",
                         i, pix_ready_o, {m_cyc_o, m_stb_o, m_we_o}, m_adr_o, m_sel_o, cap_adr, cap_sel);
            end
        end
        m_ack_i = 1'b1;
        @(posedge clk_i); #1;
        ack_cyc = cyc_cnt;
        m_ack_i = 1'b0;
        wait fork;
        auto_ack = 1'b1;
        checks++;
        if (acc_cyc !== ack_cyc + 1) begin
            errors++;
            $display("FAIL bp_accept_after_ack: accepted cycle %0d expected %0d", acc_cyc, ack_cyc + 1);
        end
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].adr !== 32'h5000 || obs_q[0].sel !== 32'hF ||
            obs_q[0].dat !== {224'h0, c2}) begin
            errors++;
            $display("FAIL bp_second_write: got %0d writes, expected one at 00005000 sel f dat %h",
                     obs_q.size(), c2);
        end
    endtask

    task automatic test_random();
        logic [31:0] line_adr, adr, col;
        logic [1:0]  dep;
        int          nbad;
        obs_q.delete();
        exp_q.delete();
        mvalid = 1'b0;
        ack_delay = $urandom_range(0, 3);
        line_adr = 32'h8000;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 3) line_adr = 32'h8000 + 32'($urandom_range(0, 2)) * 32;
            adr = line_adr | 32'($urandom_range(0, 31));
            col = $urandom;
            dep = 2'($urandom_range(0, 3));
            model_pix(adr, col, int'(dep));
            send_pix(adr, col, dep);
        end
        model_flush();
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        nbad = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].adr !== exp_q[i].adr || obs_q[i].sel !== exp_q[i].sel ||
                obs_q[i].dat !== exp_q[i].dat) begin
                errors++;
                nbad++;
                if (nbad < 4)
                    $display("FAIL rand_write_%0d: got adr=%h sel=%h dat=%h expected adr=%h sel=%h dat=%h",
                             i, obs_q[i].adr, obs_q[i].sel, obs_q[i].dat,
                             exp_q[i].adr, exp_q[i].sel, exp_q[i].dat);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_timeout();
        obs_q.delete();
        send_pix(32'h6008, 32'h77, 2'd0);
`ifdef GFX_COALESCE_TIMEOUT_EN
        wait_idle();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].adr !== 32'h6000 || obs_q[0].sel !== 32'h100) begin
            errors++;
            $display("FAIL timeout_write: got %0d writes, expected one at 00006000 sel 100", obs_q.size());
        end
        checks++;
        if (rise_cyc !== acc_cyc + TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency: cyc rose at %0d expected %0d", rise_cyc, acc_cyc + TMO + 1);
        end
`else
        repeat (100) begin @(posedge clk_i); #1; end
        checks++;
        if (obs_q.size() !== 0 || idle_o !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: got %0d writes idle=%b, expected 0 writes idle=0",
                     obs_q.size(), idle_o);
        end
        do_flush();
        wait_idle();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0].sel !== 32'h100) begin
            errors++;
            $display("FAIL no_timeout_flush: got %0d writes, expected one with sel 100", obs_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        auto_ack = 1'b0;
        obs_q.delete();
        send_pix(32'h7000, 32'hDEAD_BEEF, 2'd3);
        do_flush();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_i); #1;
            seen = m_cyc_o;
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (!seen || m_cyc_o !== 1'b0 || idle_o !== 1'b1 || m_sel_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: cycle_seen=%b cyc=%b idle=%b sel=%h expected 1 0 1 0",
                     seen, m_cyc_o, idle_o, m_sel_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        auto_ack = 1'b1;
        repeat (30) begin @(posedge clk_i); #1; end
        checks++;
        if (obs_q.size() !== 0 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d writes idle=%b expected 0 writes idle=1",
                     obs_q.size(), idle_o);
        end
    endtask

    initial begin
        test_reset();
        test_span_8bpp();
        test_mixed_depth();
        test_line_end();
        test_back_pressure();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
